// File: rtl/jtpopeye_vtimer.sv
// jtpopeye_vtimer -- video timing generator (H/V counters, blanking, sync,
// object-buffer init strobe and line/frame start pulses).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   cen          pixel clock enable; counters advance only when high
//   RV_n         screen flip (active low); inverts H and V outputs
//   H, V         horizontal / vertical count with flip applied
//   HB, VB       horizontal / vertical blank
//   HBD_n        HB with the DMA window at the end of HB removed (active low)
//   HS, VS       horizontal / vertical sync (active high)
//   INITEO_n     one-pixel strobe at the first pixel of vertical blank
//   line_start   one-clk pulse entering hc=0
//   frame_start  one-clk pulse entering hc=0, vc=0
//
// Build option: define JTPOPEYE_VTIMER_SYNC_EN to generate HS/VS; when it is
// undefined both sync outputs are tied low and no sync decode exists.

module jtpopeye_vtimer #(
  parameter int HW       = 9,
  parameter int VW       = 9,
  parameter int HTOTAL   = 384,
  parameter int HACT     = 256,
  parameter int HBD_EXT  = 16,
  parameter int HS_START = 288,
  parameter int HS_LEN   = 32,
  parameter int VTOTAL   = 264,
  parameter int VACT     = 224,
  parameter int VS_START = 240,
  parameter int VS_LEN   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          RV_n,
  output logic [HW-1:0] H,
  output logic [VW-1:0] V,
  output logic          HB,
  output logic          HBD_n,
  output logic          VB,
  output logic          HS,
  output logic          VS,
  output logic          INITEO_n,
  output logic          line_start,
  output logic          frame_start
);

  generate
    if (HTOTAL > 2**HW || VTOTAL > 2**VW || HACT >= HTOTAL ||
        VACT >= VTOTAL || HBD_EXT > HTOTAL - HACT) begin : g_bad_params
      $fatal(1, "jtpopeye_vtimer: inconsistent timing parameters");
    end
  endgenerate

  // Thresholds are one bit wider than the counters so that limits equal to
  // 2**HW (or 2**VW) still compare correctly.
  localparam logic [HW:0]   HACT_X    = (HW+1)'(HACT);
  localparam logic [HW:0]   HBD_END_X = (HW+1)'(HTOTAL - 1 - HBD_EXT);
  localparam logic [VW:0]   VACT_X    = (VW+1)'(VACT);
  localparam logic [HW-1:0] HLAST     = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] VLAST     = VW'(VTOTAL - 1);

  logic [HW-1:0] hc_reg, hc_next;
  logic [VW-1:0] vc_reg, vc_next;
  logic [HW:0]   hx;
  logic [VW:0]   vx;

  always_comb begin
    hc_next = hc_reg + 1'b1;
    vc_next = vc_reg;
    if (hc_reg == HLAST) begin
      hc_next = '0;
      vc_next = (vc_reg == VLAST) ? '0 : vc_reg + 1'b1;
    end
  end

  // Every output is decoded from the *next* count so it lands in the same
  // cycle as the counter update.
  assign hx = {1'b0, hc_next};
  assign vx = {1'b0, vc_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_reg      <= '0;
      vc_reg      <= '0;
      H           <= '0;
      V           <= '0;
      HB          <= 1'b0;
      HBD_n       <= 1'b1;
      VB          <= 1'b0;
      INITEO_n    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (cen) begin
        hc_reg      <= hc_next;
        vc_reg      <= vc_next;
        // Flip is sampled only here, so RV_n changes wait for the next cen.
        H           <= RV_n ? hc_next : ~hc_next;
        V           <= RV_n ? vc_next : ~vc_next;
        HB          <= hx >= HACT_X;
        HBD_n       <= !(hx >= HACT_X && hx <= HBD_END_X);
        VB          <= vx >= VACT_X;
        INITEO_n    <= !(hc_next == '0 && vx == VACT_X);
        line_start  <= hc_next == '0;
        frame_start <= hc_next == '0 && vc_next == '0;
      end
    end
  end

`ifdef JTPOPEYE_VTIMER_SYNC_EN
  localparam logic [HW:0] HS_BEG_X = (HW+1)'(HS_START);
  localparam logic [HW:0] HS_END_X = (HW+1)'(HS_START + HS_LEN);
  localparam logic [VW:0] VS_BEG_X = (VW+1)'(VS_START);
  localparam logic [VW:0] VS_END_X = (VW+1)'(VS_START + VS_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HS <= 1'b0;
      VS <= 1'b0;
    end else if (cen) begin
      HS <= hx >= HS_BEG_X && hx < HS_END_X;
      VS <= vx >= VS_BEG_X && vx < VS_END_X;
    end
  end
`else
  assign HS = 1'b0;
  assign VS = 1'b0;
`endif

endmodule
